sram_like_arbiter: RTL and testbench
====================================

// Module: sram_like_arbiter
// PURPOSE
//  Shares one sram-like memory port between the CPU's instruction-fetch master (M0)
//  and its load/store master (M1). Sits between mycpu_top's inst/data sides and the
//  single bridge toward the memory system. Sequences each transaction through
//  arbitration, address, and data phases, with one transaction outstanding at a time.
// PARAMETERS
//  ADDR_W  32  address width of all ports
//  DATA_W  32  read/write data width of all ports
// PORTS
//  clk         in   1       clock; all state changes on the rising edge
//  resetn      in   1       asynchronous, active-low reset
//  mN_req      in   1       master N request (N=0 inst, N=1 data); held until mN_addr_ok
//  mN_wr       in   1       1=write, 0=read
//  mN_size     in   2       0=byte, 1=half, 2=word
//  mN_addr     in   ADDR_W  byte address
//  mN_wdata    in   DATA_W  write data
//  mN_addr_ok  out  1       request accepted (1-cycle pulse)
//  mN_data_ok  out  1       read data valid or write done (1-cycle pulse)
//  mN_rdata    out  DATA_W  read data; 0 unless mN_data_ok
//  s_req/s_wr/s_size/s_addr/s_wdata  out  1/1/2/ADDR_W/DATA_W  shared slave request
//  s_addr_ok   in   1       slave accepted the request
//  s_data_ok   in   1       slave data phase complete
//  s_rdata     in   DATA_W  slave read data
// BEHAVIOUR
//  - FSM states: IDLE -> ADDR -> DATA -> IDLE. The grant register gnt (0/1) is valid in ADDR and DATA.
//  - IDLE: if any mN_req=1, pick a winner, register it in gnt, and go to ADDR next cycle.
//    This gives a 1-cycle arbitration latency. No slave outputs are asserted in IDLE.
//  - ADDR: s_req = m[gnt]_req. s_wr, s_size, s_addr, and s_wdata are driven live from m[gnt].
//    On s_addr_ok & s_req: pulse m[gnt]_addr_ok in the same cycle (combinational) and go to DATA.
//    If m[gnt]_req drops before acceptance, abort to IDLE with no addr_ok pulse.
//  - DATA: s_req=0. On s_data_ok: pulse m[gnt]_data_ok in the same cycle,
//    set m[gnt]_rdata = s_rdata, and go to IDLE.
//  - s_data_ok outside DATA is ignored. s_addr_ok outside ADDR is ignored.
//  - The non-granted master never sees addr_ok or data_ok. Its req stays pending.
//  - Minimum transaction is 3 cycles (IDLE, ADDR, DATA), so the next grant is evaluated
//    in the IDLE cycle that follows.
//  - Arbitration policy without ARB_RR_EN: fixed priority; M1 (data) wins any tie.
//  - Reset (asynchronous, any state, including mid-DATA):
//    state=IDLE, gnt=0, every output = 0.
//    A slave response still in flight after reset is discarded (it is ignored because the FSM is in IDLE).
//  - Widths: outputs are pure muxes of the inputs. No arithmetic and no data registering.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin arbitration.
//    Register last_gnt holds the master granted most recently; its reset value is 0.
//    On a tie the winner is ~last_gnt, so the first tie after reset goes to M1.
//    last_gnt updates on every IDLE->ADDR transition.
//  ARB_RR_EN undefined: no last_gnt register; the fixed M1 priority above applies.
// STRUCTURE
//  Shared package/header arb_defs: state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2),
//  master id constants M_INST=1'b0 and M_DATA=1'b1, and size codes SZ_B/SZ_H/SZ_W.
//  One sub-module, arb_pick: combinational winner select taking req0, req1 and last_gnt,
//  plus the ARB_RR_EN variant. The FSM and muxes stay in the top.
// TESTING
//  1. M0 reads 0xBFC00000; s_addr_ok in ADDR; s_data_ok next cycle with s_rdata=0x3C1DBFC0
//     -> m0_addr_ok pulses once; m0_data_ok=1 with m0_rdata=0x3C1DBFC0; m1 outputs stay 0.
//  2. M0 and M1 both raise req in the same IDLE cycle (fixed priority)
//     -> M1 transaction completes first; M0 is granted in the following IDLE and completes second.
//  3. ARB_RR_EN, both masters requesting continuously for 4 transactions
//     -> grant order is M1, M0, M1, M0.
//  4. M1 writes size=0, addr=0x80000003, wdata=0x000000AB
//     -> slave sees s_wr=1, s_size=0, the same addr/wdata; m1_data_ok pulses; m1_rdata=0.
//  5. resetn=0 asynchronously while in DATA
//     -> all outputs 0 immediately and state IDLE; a later s_data_ok is ignored;
//     the next M0 request completes normally.
//  6. M0 drops req in ADDR before s_addr_ok
//     -> FSM returns to IDLE, s_req=0 next cycle, no m0_addr_ok and no m0_data_ok.

Source files
------------

// File: rtl/arb_defs.sv
// Shared definitions for the sram-like two-master arbiter: FSM state
// encoding, master ids and transfer size codes.
package arb_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic M_INST = 1'b0;
  localparam logic M_DATA = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the instruction-fetch master (M0)
// and the load/store master (M1).
// Build option ARB_RR_EN: a tie goes to the master not granted last time.
// Without it, M1 wins every tie and i_last_gnt is ignored.
module arb_pick
  import arb_defs::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_gnt,
  output logic o_any,
  output logic o_gnt
);

  assign o_any = i_req0 | i_req1;

`ifdef ARB_RR_EN
  // Round-robin: alternate on a tie, otherwise the sole requester wins.
  always_comb begin
    o_gnt = M_INST;
    if (i_req0 && i_req1) begin
      o_gnt = ~i_last_gnt;
    end else if (i_req1) begin
      o_gnt = M_DATA;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last_gnt;

  // Fixed priority: the data master wins whenever it is requesting.
  always_comb begin
    o_gnt = i_req1 ? M_DATA : M_INST;
  end
`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave port between M0 (instruction fetch) and
// M1 (load/store). One transaction is outstanding at a time; the slave
// side is a pure mux of the granted master, nothing is registered except
// the FSM state, the grant and (with ARB_RR_EN) the last grant.
// Build option ARB_RR_EN selects round-robin instead of fixed M1 priority.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | no transaction; arbitrate, latch winner into r_gnt
//  ADDR  | present granted master's request until s_addr_ok, or abort
//        | when the master withdraws its req
//  DATA  | wait for s_data_ok, return it to the granted master
module sram_like_arbiter
  import arb_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [1:0]        m0_size,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [1:0]        m1_size,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DATA_W-1:0] s_rdata
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_gnt;
  logic   w_gnt_nxt;

  logic   w_any;
  logic   w_pick;
  logic   w_last_gnt;

  logic              w_sel_req;
  logic              w_sel_wr;
  logic [1:0]        w_sel_size;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  arb_pick u_pick (
    .i_req0     (m0_req),
    .i_req1     (m1_req),
    .i_last_gnt (w_last_gnt),
    .o_any      (w_any),
    .o_gnt      (w_pick)
  );

`ifdef ARB_RR_EN
  logic r_last_gnt;

  // Remember who was granted on each IDLE->ADDR transition.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_gnt <= M_INST;
    end else if (r_state == IDLE && w_any) begin
      r_last_gnt <= w_pick;
    end
  end

  assign w_last_gnt = r_last_gnt;
`else
  assign w_last_gnt = M_INST;
`endif

  // State and grant registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_gnt   <= M_INST;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  // Request fields of the currently granted master.
  always_comb begin
    if (r_gnt == M_DATA) begin
      w_sel_req   = m1_req;
      w_sel_wr    = m1_wr;
      w_sel_size  = m1_size;
      w_sel_addr  = m1_addr;
      w_sel_wdata = m1_wdata;
    end else begin
      w_sel_req   = m0_req;
      w_sel_wr    = m0_wr;
      w_sel_size  = m0_size;
      w_sel_addr  = m0_addr;
      w_sel_wdata = m0_wdata;
    end
  end

  // Next state, grant and all handshake outputs; everything idles at zero.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    s_req       = 1'b0;
    s_wr        = 1'b0;
    s_size      = '0;
    s_addr      = '0;
    s_wdata     = '0;
    m0_addr_ok  = 1'b0;
    m0_data_ok  = 1'b0;
    m0_rdata    = '0;
    m1_addr_ok  = 1'b0;
    m1_data_ok  = 1'b0;
    m1_rdata    = '0;

    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gnt_nxt   = w_pick;
          w_state_nxt = ADDR;
        end
      end

      ADDR: begin
        s_req   = w_sel_req;
        s_wr    = w_sel_wr;
        s_size  = w_sel_size;
        s_addr  = w_sel_addr;
        s_wdata = w_sel_wdata;
        if (!w_sel_req) begin
          // Master withdrew before acceptance: nothing was issued.
          w_state_nxt = IDLE;
        end else if (s_addr_ok) begin
          if (r_gnt == M_DATA) begin
            m1_addr_ok = 1'b1;
          end else begin
            m0_addr_ok = 1'b1;
          end
          w_state_nxt = DATA;
        end
      end

      DATA: begin
        if (s_data_ok) begin
          if (r_gnt == M_DATA) begin
            m1_data_ok = 1'b1;
            m1_rdata   = s_rdata;
          end else begin
            m0_data_ok = 1'b1;
            m0_rdata   = s_rdata;
          end
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios followed by
// randomized transactions checked against a transaction-level model.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req, m0_wr, m0_addr_ok, m0_data_ok;
  logic [1:0]  m0_size;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wr, m1_addr_ok, m1_data_ok;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the masters' pending requests and of the arbiter's memory.
  bit          pend [2];
  logic        wr_q [2];
  logic [1:0]  sz_q [2];
  logic [31:0] ad_q [2];
  logic [31:0] wd_q [2];
  bit          model_last;

  always #5 clk = ~clk;

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_req     (m0_req),
    .m0_wr      (m0_wr),
    .m0_size    (m0_size),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_addr_ok (m0_addr_ok),
    .m0_data_ok (m0_data_ok),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_wr      (m1_wr),
    .m1_size    (m1_size),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_addr_ok (m1_addr_ok),
    .m1_data_ok (m1_data_ok),
    .m1_rdata   (m1_rdata),
    .s_req      (s_req),
    .s_wr       (s_wr),
    .s_size     (s_size),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_addr_ok  (s_addr_ok),
    .s_data_ok  (s_data_ok),
    .s_rdata    (s_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag,
                          input logic e_sreq, input logic e_swr, input logic [1:0] e_ssz,
                          input logic [31:0] e_saddr, input logic [31:0] e_swd,
                          input logic e_ao0, input logic e_do0, input logic [31:0] e_rd0,
                          input logic e_ao1, input logic e_do1, input logic [31:0] e_rd1);
    chk({tag, "_s_req"},      32'(s_req),      32'(e_sreq));
    chk({tag, "_s_wr"},       32'(s_wr),       32'(e_swr));
    chk({tag, "_s_size"},     32'(s_size),     32'(e_ssz));
    chk({tag, "_s_addr"},     s_addr,          e_saddr);
    chk({tag, "_s_wdata"},    s_wdata,         e_swd);
    chk({tag, "_m0_addr_ok"}, 32'(m0_addr_ok), 32'(e_ao0));
    chk({tag, "_m0_data_ok"}, 32'(m0_data_ok), 32'(e_do0));
    chk({tag, "_m0_rdata"},   m0_rdata,        e_rd0);
    chk({tag, "_m1_addr_ok"}, 32'(m1_addr_ok), 32'(e_ao1));
    chk({tag, "_m1_data_ok"}, 32'(m1_data_ok), 32'(e_do1));
    chk({tag, "_m1_rdata"},   m1_rdata,        e_rd1);
  endtask

  task automatic chk_zero(input string tag);
    chk_outs(tag, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic drive_masters();
    m0_req = pend[0]; m0_wr = wr_q[0]; m0_size = sz_q[0]; m0_addr = ad_q[0]; m0_wdata = wd_q[0];
    m1_req = pend[1]; m1_wr = wr_q[1]; m1_size = sz_q[1]; m1_addr = ad_q[1]; m1_wdata = wd_q[1];
  endtask

  task automatic set_master(input int idx, input logic wr, input logic [1:0] sz,
                            input logic [31:0] ad, input logic [31:0] wd);
    pend[idx] = 1'b1; wr_q[idx] = wr; sz_q[idx] = sz; ad_q[idx] = ad; wd_q[idx] = wd;
  endtask

  task automatic clear_masters();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive_masters();
  endtask

  // Winner by the arbitration rule: lone requester wins; a tie goes to M1
  // under fixed priority, or to the master not granted last under round-robin.
  function automatic bit model_pick(input bit p0, input bit p1);
    if (p0 && p1) begin
`ifdef ARB_RR_EN
      return !model_last;
`else
      return 1'b1;
`endif
    end
    return p1;
  endfunction

  // One full transaction starting in IDLE: g is the master expected to win,
  // aw/dw are slave stall cycles before addr_ok/data_ok.
  task automatic run_txn(input string tag, input bit g, input int aw, input int dw,
                         input logic [31:0] rd);
    logic [31:0] e_rd;
    drive_masters();
    s_addr_ok = 1'($urandom);
    s_data_ok = 1'($urandom);
    s_rdata   = $urandom;
    #1 chk_zero({tag, "_idle"});
    tick();
    repeat (aw) begin
      s_addr_ok = 1'b0;
      s_data_ok = 1'($urandom);
      #1 chk_outs({tag, "_addr_wait"}, 1'b1, wr_q[g], sz_q[g], ad_q[g], wd_q[g],
                  1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      tick();
    end
    s_addr_ok = 1'b1;
    s_data_ok = 1'($urandom);
    #1 chk_outs({tag, "_addr_ok"}, 1'b1, wr_q[g], sz_q[g], ad_q[g], wd_q[g],
                (g == 1'b0), 1'b0, 32'd0, (g == 1'b1), 1'b0, 32'd0);
    tick();
    pend[g] = 1'b0;
    drive_masters();
    s_addr_ok = 1'b0;
    repeat (dw) begin
      s_data_ok = 1'b0;
      s_addr_ok = 1'($urandom);
      #1 chk_zero({tag, "_data_wait"});
      tick();
    end
    e_rd      = wr_q[g] ? 32'd0 : rd;
    s_data_ok = 1'b1;
    s_addr_ok = 1'($urandom);
    s_rdata   = e_rd;
    #1 chk_outs({tag, "_data_ok"}, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0,
                1'b0, (g == 1'b0), (g == 1'b0) ? e_rd : 32'd0,
                1'b0, (g == 1'b1), (g == 1'b1) ? e_rd : 32'd0);
    tick();
    s_data_ok  = 1'b0;
    s_addr_ok  = 1'b0;
    model_last = g;
  endtask

  initial begin
    bit exp_g;
    bit exp_seq [4];

    // Reset: every output low, even with slave strobes wiggling.
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; wr_q[i] = 1'b0; sz_q[i] = 2'd0; ad_q[i] = 32'd0; wd_q[i] = 32'd0;
    end
    model_last = 1'b0;
    drive_masters();
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'd0;
    #1 chk_zero("reset");
    @(posedge clk);
    #1;
    s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'hDEADBEEF;
    #1 chk_zero("reset_held");
    s_addr_ok = 1'b0; s_data_ok = 1'b0;
    tick();
    resetn = 1'b1;

    // 1: M0 word read from the boot vector.
    set_master(0, 1'b0, 2'd2, 32'hBFC00000, 32'd0);
    run_txn("t1", 1'b0, 0, 0, 32'h3C1DBFC0);

    // 2: simultaneous requests, M1 first then M0 in the following IDLE.
    clear_masters();
    set_master(0, 1'b0, 2'd2, 32'h00001000, 32'd0);
    set_master(1, 1'b0, 2'd1, 32'h00002002, 32'd0);
    run_txn("t2_first", 1'b1, 1, 1, 32'h11112222);
    run_txn("t2_second", 1'b0, 0, 2, 32'h33334444);

    // 3: both masters requesting continuously for four transactions.
`ifdef ARB_RR_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      if (!pend[0]) set_master(0, 1'b0, 2'd2, 32'h00003000 + 32'(i * 4), 32'd0);
      if (!pend[1]) set_master(1, 1'b1, 2'd2, 32'h00004000 + 32'(i * 4), 32'hA0 + 32'(i));
      run_txn($sformatf("t3_%0d", i), exp_seq[i], i % 2, 1, 32'h55550000 + 32'(i));
    end

    // 4: M1 byte write.
    clear_masters();
    set_master(1, 1'b1, 2'd0, 32'h80000003, 32'h000000AB);
    run_txn("t4", 1'b1, 0, 1, 32'd0);

    // 5: asynchronous reset while in DATA, late s_data_ok ignored.
    clear_masters();
    set_master(0, 1'b0, 2'd2, 32'h10000000, 32'd0);
    drive_masters();
    #1;
    tick();
    s_addr_ok = 1'b1;
    #1 chk("t5_m0_addr_ok", 32'(m0_addr_ok), 32'd1);
    tick();
    pend[0] = 1'b0;
    drive_masters();
    s_addr_ok = 1'b0;
    #1 chk_zero("t5_in_data");
    #1 resetn = 1'b0;
    #1 chk_zero("t5_reset_now");
    s_data_ok = 1'b1;
    s_rdata   = 32'hCAFEF00D;
    #1 chk_zero("t5_reset_data_ok");
    tick();
    resetn = 1'b1;
    #1 chk_zero("t5_late_data_ok");
    tick();
    s_data_ok  = 1'b0;
    model_last = 1'b0;
    set_master(0, 1'b0, 2'd2, 32'h10000004, 32'd0);
    run_txn("t5_after", 1'b0, 1, 0, 32'h76543210);

    // 6: M0 withdraws its request in ADDR before s_addr_ok.
    clear_masters();
    set_master(0, 1'b0, 2'd2, 32'h20000000, 32'd0);
    drive_masters();
    #1;
    tick();
    model_last = 1'b0;
    #1 chk("t6_addr_s_req", 32'(s_req), 32'd1);
    tick();
    pend[0] = 1'b0;
    drive_masters();
    s_addr_ok = 1'b1;
    #1 chk("t6_drop_s_req", 32'(s_req), 32'd0);
    chk("t6_drop_m0_addr_ok", 32'(m0_addr_ok), 32'd0);
    chk("t6_drop_m1_addr_ok", 32'(m1_addr_ok), 32'd0);
    tick();
    s_addr_ok = 1'b0;
    s_data_ok = 1'b1;
    #1 chk_zero("t6_idle");
    tick();
    s_data_ok = 1'b0;

    // Randomized traffic against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1))
          set_master(i, 1'($urandom), 2'($urandom_range(0, 2)), $urandom, $urandom);
      end
      if (!pend[0] && !pend[1])
        set_master(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom_range(0, 2)),
                   $urandom, $urandom);
      exp_g = model_pick(pend[0], pend[1]);
      run_txn($sformatf("rnd%0d", n), exp_g, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
